// File: rtl/fsm3s_pkg.sv
// Shared types and next-state function for the time-shared "101" detector.
package fsm3s_pkg;

  typedef enum logic [1:0] {
    ST_A = 2'd0,
    ST_B = 2'd1,
    ST_C = 2'd2,
    ST_D = 2'd3
  } det_state_e;

  // Moore "101" detector with overlap; ST_D is the match state.
  function automatic det_state_e fsm3s_next(input det_state_e s, input logic b);
    det_state_e n;
    n = ST_A;
    unique case (s)
      ST_A:    n = b ? ST_B : ST_A;
      ST_B:    n = b ? ST_B : ST_C;
      ST_C:    n = b ? ST_D : ST_A;
      ST_D:    n = b ? ST_B : ST_C;
      default: n = ST_A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fsm3s_channel_sched_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
module rr_arbiter #(
  parameter  int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] grant_idx,
  output logic           grant_vld
);

  logic [CHW-1:0] last_q;
  logic [CHW-1:0] last_d;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int unsigned off = 1; off <= NCH; off++) begin
      int unsigned cand;
      cand = int'(last_q) + off;
      if (cand >= NCH) cand = cand - NCH;
      if (!grant_vld && req[CHW'(cand)]) begin
        grant_vld              = 1'b1;
        grant_idx              = CHW'(cand);
        grant[CHW'(cand)]      = 1'b1;
      end
    end
    last_d = grant_vld ? grant_idx : last_q;
  end

  // Reset to the top index so channel 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= CHW'(NCH - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/fsm3s_channel_sched.sv
// One "101" detector time-shared across NCH serial channels via saved contexts
// and round-robin arbitration; emits tagged detection pulses and a hit count.
module fsm3s_channel_sched
  import fsm3s_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int CNTW = 16,
  localparam int CHW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  ch_valid,
  input  logic [NCH-1:0]  ch_bit,
  input  logic [NCH-1:0]  ch_clear,
  output logic [NCH-1:0]  ch_ready,
  output logic            det_valid,
  output logic [CHW-1:0]  det_ch,
  output logic [CNTW-1:0] hit_count,
  output logic            busy
);

  logic [NCH-1:0]  eligible;
  logic [NCH-1:0]  grant;
  logic [CHW-1:0]  grant_idx;
  logic            grant_vld;

  det_state_e      ctx_q [NCH];
  det_state_e      ctx_d [NCH];
  det_state_e      nstate;

  logic            det_valid_q, det_valid_d;
  logic [CHW-1:0]  det_ch_q, det_ch_d;
  logic [CNTW-1:0] hit_count_q, hit_count_d;

  // A clearing channel is withheld from arbitration so its bit stays pending.
  assign eligible = ch_valid & ~ch_clear;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign ch_ready = reset ? '0 : grant;
  assign busy     = |ch_valid;

  always_comb begin
    ctx_d       = ctx_q;
    nstate      = fsm3s_next(ctx_q[grant_idx], ch_bit[grant_idx]);
    det_valid_d = grant_vld && (nstate == ST_D);
    det_ch_d    = det_valid_d ? grant_idx : det_ch_q;
    hit_count_d = hit_count_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_clear[i])   ctx_d[i] = ST_A;
      else if (grant[i]) ctx_d[i] = nstate;
    end
    if (det_valid_d && (hit_count_q != '1)) hit_count_d = hit_count_q + CNTW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) ctx_q[i] <= ST_A;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      hit_count_q <= '0;
    end else begin
      ctx_q       <= ctx_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_fsm3s_channel_sched.sv
// Directed bench: a default-width instance plus a 3-bit-counter twin for saturation.
module tb_fsm3s_channel_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  valid, bits, clr;

  logic [3:0]  ready;
  logic        det_valid;
  logic [1:0]  det_ch;
  logic [15:0] hit;
  logic        busy;

  logic [3:0]  s_ready;
  logic        s_det_valid;
  logic [1:0]  s_det_ch;
  logic [2:0]  s_hit;
  logic        s_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fsm3s_channel_sched #(.NCH(4), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .ch_valid(valid), .ch_bit(bits), .ch_clear(clr),
    .ch_ready(ready), .det_valid(det_valid), .det_ch(det_ch),
    .hit_count(hit), .busy(busy)
  );

  fsm3s_channel_sched #(.NCH(4), .CNTW(3)) u_sat (
    .clk(clk), .reset(reset), .ch_valid(valid), .ch_bit(bits), .ch_clear(clr),
    .ch_ready(s_ready), .det_valid(s_det_valid), .det_ch(s_det_ch),
    .hit_count(s_hit), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic dv, input logic [1:0] dc,
                         input logic [15:0] h, input logic [2:0] sh);
    chk({tag, "_det_valid"}, 32'(det_valid), 32'(dv));
    chk({tag, "_det_ch"},    32'(det_ch),    32'(dc));
    chk({tag, "_hit"},       32'(hit),       32'(h));
    chk({tag, "_sat_hit"},   32'(s_hit),     32'(sh));
  endtask

  // Present one bit on channel ch alone, check ready, clock it, check outputs.
  task automatic one_bit(input string tag, input int ch, input logic b,
                         input logic dv, input logic [1:0] dc,
                         input logic [15:0] h, input logic [2:0] sh);
    valid = 4'b0001 << ch;
    bits  = 4'(b) << ch;
    clr   = '0;
    #1;
    chk({tag, "_ready"}, 32'(ready), 32'(4'b0001 << ch));
    tick();
    chk_out(tag, dv, dc, h, sh);
  endtask

  initial begin
    logic [2:0] seq;
    int         cnt [4];
    logic [3:0] rdy_tab [5];
    logic       ch2_done;

    reset = 1'b1;
    valid = 4'hF;
    bits  = '0;
    clr   = '0;
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_busy",  32'(busy),  32'h1);
    chk_out("rst", 1'b0, 2'd0, 16'd0, 3'd0);
    tick();
    tick();
    reset = 1'b0;
    valid = '0;
    tick();
    chk_out("idle", 1'b0, 2'd0, 16'd0, 3'd0);

    // All four channels stream 1,0,1; grants rotate 0,1,2,3 from reset.
    seq = 3'b101;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 4; i++) begin
        valid[i] = (cnt[i] < 3);
        bits[i]  = (cnt[i] < 3) ? seq[2 - cnt[i]] : 1'b0;
      end
      #1;
      chk("rr_ready", 32'(ready), 32'(4'b0001 << (c % 4)));
      cnt[c % 4]++;
      tick();
      if (c >= 8) chk_out("rr", 1'b1, 2'(c - 8), 16'(c - 7), 3'(c - 7));
      else        chk_out("rr", 1'b0, 2'd0, 16'd0, 3'd0);
    end
    valid = '0;
    tick();
    chk_out("rr_end", 1'b0, 2'd3, 16'd4, 3'd4);

    // Channel 0 alone (context D): 1,0,1,0,1 matches on 3rd and 5th bits.
    one_bit("c0_b1", 0, 1'b1, 1'b0, 2'd3, 16'd4, 3'd4);
    one_bit("c0_b2", 0, 1'b0, 1'b0, 2'd3, 16'd4, 3'd4);
    one_bit("c0_b3", 0, 1'b1, 1'b1, 2'd0, 16'd5, 3'd5);
    one_bit("c0_b4", 0, 1'b0, 1'b0, 2'd0, 16'd5, 3'd5);
    one_bit("c0_b5", 0, 1'b1, 1'b1, 2'd0, 16'd6, 3'd6);

    // Channel 1: 1,0 then clear with valid; the next 1 must land in B, not D.
    one_bit("clr_b1", 1, 1'b1, 1'b0, 2'd0, 16'd6, 3'd6);
    one_bit("clr_b2", 1, 1'b0, 1'b0, 2'd0, 16'd6, 3'd6);
    valid = 4'b0010;
    bits  = 4'b0010;
    clr   = 4'b0010;
    #1;
    chk("clr_ready", 32'(ready), 32'h0);
    chk("clr_busy",  32'(busy),  32'h1);
    tick();
    chk_out("clr_cyc", 1'b0, 2'd0, 16'd6, 3'd6);
    one_bit("clr_b3", 1, 1'b1, 1'b0, 2'd0, 16'd6, 3'd6);
    one_bit("clr_b4", 1, 1'b0, 1'b0, 2'd0, 16'd6, 3'd6);
    one_bit("clr_b5", 1, 1'b1, 1'b1, 2'd1, 16'd7, 3'd7);

    // Channel 3 (context D): 0,1 three times; the 3-bit twin holds at 7.
    for (int k = 0; k < 3; k++) begin
      one_bit("sat_b0", 3, 1'b0, 1'b0, 2'd1 + 2'(k > 0) * 2'd2, 16'(7 + k), 3'd7);
      one_bit("sat_b1", 3, 1'b1, 1'b1, 2'd3, 16'(8 + k), 3'd7);
    end

    // Channel 2 contends with 0 and 3; its first 0 then 1 must both be used.
    rdy_tab[0] = 4'b0001; rdy_tab[1] = 4'b0100; rdy_tab[2] = 4'b1000;
    rdy_tab[3] = 4'b0001; rdy_tab[4] = 4'b0100;
    ch2_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      valid = 4'b1101;
      bits  = {1'b0, ch2_done, 2'b00};
      clr   = '0;
      #1;
      chk("wait_ready", 32'(ready), 32'(rdy_tab[c]));
      if (ready[2]) ch2_done = 1'b1;
      tick();
      if (c == 4) chk_out("wait", 1'b1, 2'd2, 16'd11, 3'd7);
      else        chk_out("wait", 1'b0, 2'd3, 16'd10, 3'd7);
    end
    valid = '0;

    // Channel 1 (context D) 0,1 then asynchronous reset between edges.
    one_bit("ar_b0", 1, 1'b0, 1'b0, 2'd2, 16'd11, 3'd7);
    one_bit("ar_b1", 1, 1'b1, 1'b1, 2'd1, 16'd12, 3'd7);
    valid = 4'hF;
    bits  = 4'hF;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_ready", 32'(ready), 32'h0);
    chk_out("ar_now", 1'b0, 2'd0, 16'd0, 3'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_first", 32'(ready), 32'h1);
    tick();
    chk_out("ar_after", 1'b0, 2'd0, 16'd0, 3'd0);
    valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
